pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the 13-bit program counter, the 14-bit instruction register (instr_current) and the 8-level hardware return stack.
- Acts on the decoder's per-Q-cycle strobes (instr_rd_en, instr_flush, pc_incr_en, pc_j_en, call/return) to fetch the next word, flush to NOP, or redirect flow.
- Program memory is an asynchronous ROM: prog_data is valid in the same cycle that prog_addr is presented.

Parameters:
- PC_WIDTH, 13, program counter width.
- INSTR_WIDTH, 14, instruction word width.
- STACK_DEPTH, 8, return stack entries; must be a power of two.
- NOP_WORD, 14'h0000, word loaded into the instruction register on reset and on flush.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_rd_en  in  1  load prog_data into the instruction register.
- instr_flush  in  1  load NOP_WORD into the instruction register.
- pc_incr_en  in  1  PC <= PC+1.
- pc_j_en  in  1  GOTO: PC <= {pclath[4:3], instr_current[10:0]}.
- pc_call_en  in  1  CALL: push PC, then jump as for pc_j_en.
- pc_ret_en  in  1  RETURN/RETLW/RETFIE: PC <= popped stack value.
- pcl_wr_en  in  1  data-path write to PCL.
- pcl_wr_data  in  8  value written to PCL.
- pclath  in  5  PCLATH register contents.
- prog_addr  out  PC_WIDTH  program memory address; equals the PC register.
- prog_data  in  INSTR_WIDTH  program memory read data.
- instr_current  out  INSTR_WIDTH  instruction register, feeds the decoder.
- pcl_out  out  8  PC[7:0], for data-bus reads of PCL.
- stack_ovf  out  1  sticky flag: push while stack full.
- stack_unf  out  1  sticky flag: pop while stack empty.

Behaviour:
- Reset (synchronous) values:
  - PC = 0, instr_current = NOP_WORD.
  - Stack pointer = 0, occupancy = 0.
  - stack_ovf = 0, stack_unf = 0.
  - Stack contents are don't-care.
- prog_addr and pcl_out are combinational from PC, with no extra latency.
- Instruction register update, evaluated every clk edge:
  - instr_flush=1 -> NOP_WORD. Flush beats instr_rd_en.
  - else instr_rd_en=1 -> prog_data (the word at the current PC, before this edge's PC update).
  - else hold.
- PC update priority, one per edge, highest first:
  - ret: PC <= stack[sp-1]; sp--.
  - call: stack[sp] <= PC; sp++; PC <= {pclath[4:3], instr_current[10:0]}.
  - j: PC <= {pclath[4:3], instr_current[10:0]}.
  - pcl_wr: PC <= {pclath[4:0], pcl_wr_data}.
  - incr: PC <= PC+1.
  - none: hold.
- Lower-priority strobes asserted in the same cycle are ignored. The decoder asserts at most one; a bench assertion checks this.
- PC invariant: while instruction at address A sits in instr_current, PC = A+1. A pushed call therefore saves the correct return address.
- Jump targets are taken from instr_current (the executing GOTO/CALL), never from prog_data.
- Increment arithmetic is modulo 2^PC_WIDTH: 0x1FFF -> 0x0000, no flag.
- Stack is circular, with sp of log2(STACK_DEPTH) bits and wrap-around indexing.
  - Push with occupancy = STACK_DEPTH: overwrites the oldest entry, sets stack_ovf; occupancy stays at STACK_DEPTH.
  - Pop with occupancy = 0: returns stack[sp-1] (stale value), sp wraps, sets stack_unf; occupancy stays 0.
  - Otherwise occupancy changes by ±1.
  - stack_ovf and stack_unf clear only on rst.
- Reset mid-operation (rst high during any strobe): reset wins; all strobes are ignored that cycle.

Decomposition:
- Shared constants go in the existing isa.vh: NOP encoding, GOTO/CALL target field [10:0], PCLATH page bits [4:3].
- One natural sub-module, return_stack: circular RAM, sp, occupancy counter, ovf/unf flags, push/pop interface.
- PC mux and instruction register stay in pc_fetch_unit.

Test Plan:
- Reset, then four NOP cycles with instr_rd_en+pc_incr_en at Q3; ROM[0]=14'h3005 (movlw 5) -> instr_current=14'h3005, PC=1.
- GOTO 0x123 in instr_current, pclath=5'b11000, pc_j_en+instr_flush -> PC=0x1923, instr_current=NOP_WORD.
- CALL 0x040 executing from address 0x010 (PC=0x011), pclath=0 -> PC=0x040, stack top=0x011. Then pc_ret_en -> PC=0x011, occupancy 0.
- 9 consecutive calls -> stack_ovf=1 after the 9th. Then 8 returns yield 9th..2nd return addresses; the entry from the 1st call is lost.
- Return on empty stack -> stack_unf=1 and PC loads stale entry. Separately, PC=0x1FFF with incr -> PC=0x0000; pcl_wr_data=0x80 with pclath=5'h02 -> PC=0x0280.
- pc_ret_en and pc_incr_en together -> ret wins. instr_flush and instr_rd_en together -> NOP loaded. rst asserted during a call -> PC=0 and occupancy 0 next cycle.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: widths, NOP encoding,
// GOTO/CALL target field and PCLATH page bits.
package pc_fetch_unit_pkg;

  localparam int PC_WIDTH    = 13;
  localparam int INSTR_WIDTH = 14;
  localparam int STACK_DEPTH = 8;
  localparam int SP_WIDTH    = $clog2(STACK_DEPTH);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 14'h0000;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INCR,
    PC_PCL,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_sel_e;

  // GOTO/CALL destination: page bits PCLATH[4:3] over the 11-bit literal.
  function automatic logic [PC_WIDTH-1:0] branch_target(input logic [4:0] pclath,
                                                         input logic [INSTR_WIDTH-1:0] instr);
    return {pclath[4:3], instr[10:0]};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_stack.sv
// Circular hardware return stack with occupancy tracking and sticky
// overflow/underflow flags. Contents are deliberately left unreset.
module pc_fetch_unit_stack
  import pc_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  output logic [PC_WIDTH-1:0] pop_data_o,
  output logic                ovf_o,
  output logic                unf_o
);

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [SP_WIDTH-1:0] sp_q, sp_m1;
  logic [SP_WIDTH:0]   occ_q;
  logic                ovf_q, unf_q;

  assign sp_m1      = sp_q - SP_WIDTH'(1);
  assign pop_data_o = mem_q[sp_m1];
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (pop_i) begin
      sp_q <= sp_m1;
      if (occ_q == '0) unf_q <= 1'b1;
      else             occ_q <= occ_q - 1'b1;
    end else if (push_i) begin
      sp_q <= sp_q + SP_WIDTH'(1);
      // Full stack: the write lands on the oldest entry, occupancy saturates.
      if (occ_q == (SP_WIDTH+1)'(STACK_DEPTH)) ovf_q <= 1'b1;
      else                                      occ_q <= occ_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !pop_i && !rst) mem_q[sp_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, instruction register and return stack,
// driven by the decoder's per-Q-cycle strobes.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_rd_en,
  input  logic                   instr_flush,
  input  logic                   pc_incr_en,
  input  logic                   pc_j_en,
  input  logic                   pc_call_en,
  input  logic                   pc_ret_en,
  input  logic                   pcl_wr_en,
  input  logic [7:0]             pcl_wr_data,
  input  logic [4:0]             pclath,
  output logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr_current,
  output logic [7:0]             pcl_out,
  output logic                   stack_ovf,
  output logic                   stack_unf
);

  logic [PC_WIDTH-1:0]    pc_q, pc_d, stk_top;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  pc_sel_e                sel;

  always_comb begin
    sel = PC_HOLD;
    if      (pc_ret_en)  sel = PC_RET;
    else if (pc_call_en) sel = PC_CALL;
    else if (pc_j_en)    sel = PC_JUMP;
    else if (pcl_wr_en)  sel = PC_PCL;
    else if (pc_incr_en) sel = PC_INCR;
  end

  // Targets come from the executing word in ir_q, never from prog_data.
  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      PC_RET:           pc_d = stk_top;
      PC_CALL, PC_JUMP: pc_d = branch_target(pclath, ir_q);
      PC_PCL:           pc_d = {pclath, pcl_wr_data};
      PC_INCR:          pc_d = pc_q + PC_WIDTH'(1);
      default:          pc_d = pc_q;
    endcase
  end

  always_comb begin
    ir_d = ir_q;
    if      (instr_flush) ir_d = NOP_WORD;
    else if (instr_rd_en) ir_d = prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      ir_q <= NOP_WORD;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  pc_fetch_unit_stack u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (sel == PC_CALL),
    .pop_i       (sel == PC_RET),
    .push_data_i (pc_q),
    .pop_data_o  (stk_top),
    .ovf_o       (stack_ovf),
    .unf_o       (stack_unf)
  );

  assign prog_addr     = pc_q;
  assign pcl_out       = pc_q[7:0];
  assign instr_current = ir_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random strobes, checked
// each cycle against a behavioural model of PC, IR and return stack.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_rd_en = 1'b0, instr_flush = 1'b0, pc_incr_en = 1'b0;
  logic        pc_j_en = 1'b0, pc_call_en = 1'b0, pc_ret_en = 1'b0, pcl_wr_en = 1'b0;
  logic [7:0]  pcl_wr_data = 8'h00;
  logic [4:0]  pclath = 5'h00;
  logic [12:0] prog_addr;
  logic [13:0] prog_data;
  logic [13:0] instr_current;
  logic [7:0]  pcl_out;
  logic        stack_ovf, stack_unf;

  logic [13:0] rom [8192];
  assign prog_data = rom[prog_addr];

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
    .pcl_wr_en(pcl_wr_en), .pcl_wr_data(pcl_wr_data), .pclath(pclath),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_current(instr_current), .pcl_out(pcl_out),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  int m_pc, m_ir, m_sp, m_occ, m_ovf, m_unf;
  int m_stk [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int opc, oir, tgt;
    opc = m_pc;
    oir = m_ir;
    tgt = (int'(pclath[4:3]) << 11) | (oir & 'h7FF);
    if (rst) begin
      m_pc = 0; m_ir = 0; m_sp = 0; m_occ = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (instr_flush)      m_ir = 0;
      else if (instr_rd_en) m_ir = int'(rom[opc]);
      if (pc_ret_en) begin
        m_sp = (m_sp + 7) % 8;
        m_pc = m_stk[m_sp];
        if (m_occ == 0) m_unf = 1; else m_occ--;
      end else if (pc_call_en) begin
        m_stk[m_sp] = opc;
        m_sp = (m_sp + 1) % 8;
        if (m_occ == 8) m_ovf = 1; else m_occ++;
        m_pc = tgt;
      end else if (pc_j_en)    m_pc = tgt;
      else if (pcl_wr_en)      m_pc = (int'(pclath) << 8) | int'(pcl_wr_data);
      else if (pc_incr_en)     m_pc = (opc + 1) % 8192;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    rst = 0; instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0;
    pc_j_en = 0; pc_call_en = 0; pc_ret_en = 0; pcl_wr_en = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("prog_addr", int'(prog_addr), m_pc);
      chk("instr_current", int'(instr_current), m_ir);
      chk("pcl_out", int'(pcl_out), m_pc & 'hFF);
      chk("stack_ovf", int'(stack_ovf), m_ovf);
      chk("stack_unf", int'(stack_unf), m_unf);
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 14'($urandom);
    rom[0]     = 14'h3005;
    rom[1]     = 14'h2923;
    rom[13'h010] = 14'h2040;
    rom[13'h027] = 14'h1234;
    for (int i = 0; i < 8; i++) m_stk[i] = 0;
    m_pc = 0; m_ir = 0; m_sp = 0; m_occ = 0; m_ovf = 0; m_unf = 0;

    #2;
    clr(); rst = 1; tick();
    clr(); chk_en = 1'b1;
    chk("reset_pc", int'(prog_addr), 0);
    chk("reset_ir", int'(instr_current), 0);
    chk("reset_flags", int'({stack_ovf, stack_unf}), 0);

    // Four Q cycles, fetch+increment at Q3
    for (int q = 0; q < 4; q++) begin
      clr();
      if (q == 3) begin instr_rd_en = 1; pc_incr_en = 1; end
      tick();
    end
    chk("fetch_ir", int'(instr_current), 'h3005);
    chk("fetch_pc", int'(prog_addr), 1);

    // GOTO 0x123 with page bits 11
    clr(); instr_rd_en = 1; pc_incr_en = 1; tick();
    clr(); pclath = 5'b11000; pc_j_en = 1; instr_flush = 1; tick();
    chk("goto_pc", int'(prog_addr), 'h1923);
    chk("goto_ir", int'(instr_current), 0);

    // CALL 0x040 from address 0x010, then return
    clr(); pclath = 5'h00; pcl_wr_en = 1; pcl_wr_data = 8'h10; tick();
    clr(); instr_rd_en = 1; pc_incr_en = 1; tick();
    chk("call_setup_pc", int'(prog_addr), 'h011);
    clr(); pc_call_en = 1; tick();
    chk("call_pc", int'(prog_addr), 'h040);
    clr(); pc_ret_en = 1; tick();
    chk("ret_pc", int'(prog_addr), 'h011);
    chk("ret_unf", int'(stack_unf), 0);

    // Nine calls: the ninth overflows and overwrites the first entry
    for (int k = 0; k < 9; k++) begin
      clr(); pcl_wr_en = 1; pcl_wr_data = 8'(8'h20 + k); tick();
      clr(); pc_call_en = 1; tick();
      if (k == 7) chk("ovf_after_8", int'(stack_ovf), 0);
    end
    chk("ovf_after_9", int'(stack_ovf), 1);
    for (int k = 0; k < 8; k++) begin
      clr(); pc_ret_en = 1; tick();
      chk("ret_chain", int'(prog_addr), 'h28 - k);
    end
    chk("unf_before_empty_pop", int'(stack_unf), 0);
    clr(); pc_ret_en = 1; tick();
    chk("empty_pop_pc", int'(prog_addr), 'h028);
    chk("empty_pop_unf", int'(stack_unf), 1);

    // PC wrap and PCL writes
    clr(); pclath = 5'h1F; pcl_wr_en = 1; pcl_wr_data = 8'hFF; tick();
    chk("pcl_1fff", int'(prog_addr), 'h1FFF);
    clr(); pc_incr_en = 1; tick();
    chk("pc_wrap", int'(prog_addr), 0);
    clr(); pclath = 5'h02; pcl_wr_en = 1; pcl_wr_data = 8'h80; tick();
    chk("pcl_0280", int'(prog_addr), 'h0280);
    chk("pcl_out_80", int'(pcl_out), 'h80);

    // Priority: ret over incr, flush over read
    clr(); pc_ret_en = 1; pc_incr_en = 1; tick();
    chk("ret_beats_incr", int'(prog_addr), 'h027);
    clr(); instr_rd_en = 1; tick();
    chk("read_ir", int'(instr_current), 'h1234);
    clr(); instr_rd_en = 1; instr_flush = 1; tick();
    chk("flush_beats_read", int'(instr_current), 0);

    // Reset during a call
    clr(); pclath = 5'h00; rst = 1; pc_call_en = 1; tick();
    chk("rst_call_pc", int'(prog_addr), 0);
    chk("rst_call_flags", int'({stack_ovf, stack_unf}), 0);
    clr(); pc_ret_en = 1; tick();
    chk("rst_occ_zero_unf", int'(stack_unf), 1);
    chk("rst_occ_zero_pc", int'(prog_addr), 'h027);

    // Random strobes
    for (int n = 0; n < 3000; n++) begin
      int r;
      clr();
      pclath      = 5'($urandom);
      pcl_wr_data = 8'($urandom);
      instr_rd_en = ($urandom_range(0, 2) == 0);
      instr_flush = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 7);
      case (r)
        0: pc_ret_en  = 1;
        1: pc_call_en = 1;
        2: pc_j_en    = 1;
        3: pcl_wr_en  = 1;
        4, 5: pc_incr_en = 1;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 4);
        case (r)
          0: pc_ret_en  = 1;
          1: pc_call_en = 1;
          2: pc_j_en    = 1;
          3: pcl_wr_en  = 1;
          default: pc_incr_en = 1;
        endcase
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    clr();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
